// File: rtl/exec_seq_pkg.sv
// Shared types and opcode constants for the multi-cycle LEGv8 execute sequencer.
package exec_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        IC_RTYPE,
        IC_LD,
        IC_ST,
        IC_CBZ,
        IC_B,
        IC_ILL
    } iclass_t;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    // CBZ and B carry register/offset bits in the low opcode field, so they match by mask.
    localparam logic [10:0] OP_CBZ      = 11'b10110100000;
    localparam logic [10:0] OP_CBZ_MASK = 11'b11111111000;
    localparam logic [10:0] OP_B        = 11'b00010100000;
    localparam logic [10:0] OP_B_MASK   = 11'b11111100000;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_PASSB = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

    function automatic logic op_match(input logic [10:0] op,
                                      input logic [10:0] val,
                                      input logic [10:0] mask);
        return (op & mask) == val;
    endfunction

endpackage

// File: rtl/exec_sequencer_instr_classifier.sv
// Combinational opcode decoder: maps the 11-bit opcode field to an instruction class.
module instr_classifier
    import exec_seq_pkg::*;
(
    input  logic [10:0] opcode,
    output iclass_t     iclass
);

    always_comb begin
        iclass = IC_ILL;
        if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_ORR) begin
            iclass = IC_RTYPE;
        end else if (opcode == OP_LDUR) begin
            iclass = IC_LD;
        end else if (opcode == OP_STUR) begin
            iclass = IC_ST;
        end else if (op_match(opcode, OP_CBZ, OP_CBZ_MASK)) begin
            iclass = IC_CBZ;
        end else if (op_match(opcode, OP_B, OP_B_MASK)) begin
            iclass = IC_B;
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle control FSM driving fetch, execute, memory and writeback enables,
// with run/halt handshake, bus-wait timeout and a retired-instruction counter.
module exec_sequencer
    import exec_seq_pkg::*;
#(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [10:0]      opcode,
    input  logic             zero,
    input  logic             if_ready,
    input  logic             mem_ready,
    output logic             if_req,
    output logic             ir_write,
    output logic [1:0]       alu_op,
    output logic             alu_src,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             busy,
    output logic             illegal,
    output logic             bus_error,
    output logic [CNT_W-1:0] instr_retired
);

    localparam int WCNT_W = $clog2(WAIT_LIMIT + 1);
    // Wait count value at the start of the last allowed non-ready cycle.
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_LIMIT - 1);

    state_t            state_q, state_d;
    iclass_t           class_q, class_d;
    iclass_t           dec_class;
    logic [WCNT_W-1:0] wait_q, wait_d;
    logic              illegal_q, illegal_d;
    logic              bus_error_q, bus_error_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              retire;
    logic              wait_last;

    instr_classifier u_classifier (
        .opcode (opcode),
        .iclass (dec_class)
    );

    assign wait_last     = (wait_q == WAIT_LAST);
    assign illegal       = illegal_q;
    assign bus_error     = bus_error_q;
    assign instr_retired = retired_q;
    assign busy          = (state_q != S_IDLE) && (state_q != S_HALT);

    always_comb begin
        state_d     = state_q;
        class_d     = class_q;
        wait_d      = '0;
        illegal_d   = illegal_q;
        bus_error_d = bus_error_q;
        retired_d   = retired_q;
        retire      = 1'b0;
        if_req      = 1'b0;
        ir_write    = 1'b0;
        alu_op      = ALU_OP_ADD;
        alu_src     = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if_req = 1'b1;
                if (if_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_last) begin
                    bus_error_d = 1'b1;
                    state_d     = S_HALT;
                end else begin
                    wait_d = wait_q + WCNT_W'(1);
                end
            end
            S_DECODE: begin
                class_d = dec_class;
                if (dec_class == IC_ILL) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (class_q)
                    IC_RTYPE: begin
                        alu_op  = ALU_OP_RTYPE;
                        state_d = S_WB;
                    end
                    IC_LD, IC_ST: begin
                        alu_op  = ALU_OP_ADD;
                        alu_src = 1'b1;
                        state_d = S_MEM;
                    end
                    IC_CBZ: begin
                        alu_op   = ALU_OP_PASSB;
                        pc_write = 1'b1;
                        pc_src   = zero;
                        retire   = 1'b1;
                    end
                    IC_B: begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                        retire   = 1'b1;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (class_q == IC_ST);
                alu_op  = ALU_OP_ADD;
                alu_src = 1'b1;
                // A ready arriving on the last allowed cycle still completes the access.
                if (mem_ready) begin
                    if (class_q == IC_ST) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_last) begin
                    bus_error_d = 1'b1;
                    state_d     = S_HALT;
                end else begin
                    wait_d = wait_q + WCNT_W'(1);
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (class_q == IC_LD);
                pc_write   = 1'b1;
                retire     = 1'b1;
            end
            S_HALT: begin
            end
            default: state_d = S_IDLE;
        endcase

        if (retire) begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = run ? S_FETCH : S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            class_q     <= IC_ILL;
            wait_q      <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            class_q     <= class_d;
            wait_q      <= wait_d;
            illegal_q   <= illegal_d;
            bus_error_q <= bus_error_d;
            retired_q   <= retired_d;
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: directed table, reset corner cases and
// randomized instructions checked against a per-instruction transaction model.
module tb_exec_sequencer;

    logic        clk = 1'b0;
    logic        reset, run, zero, if_ready, mem_ready;
    logic [10:0] opcode;
    logic        if_req, ir_write, alu_src, mem_req, mem_we, mem_to_reg;
    logic        reg_write, pc_write, pc_src, busy, illegal, bus_error;
    logic [1:0]  alu_op;
    logic [31:0] instr_retired;

    exec_sequencer #(.WAIT_LIMIT(16), .CNT_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .opcode        (opcode),
        .zero          (zero),
        .if_ready      (if_ready),
        .mem_ready     (mem_ready),
        .if_req        (if_req),
        .ir_write      (ir_write),
        .alu_op        (alu_op),
        .alu_src       (alu_src),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .busy          (busy),
        .illegal       (illegal),
        .bus_error     (bus_error),
        .instr_retired (instr_retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] op;
        bit          zero;
        int          ifd;       // non-ready fetch cycles before if_ready
        int          md;        // non-ready memory cycles before mem_ready
        bit          run_after;
        int          cycles;    // busy cycles until retire or halt
        bit          retire;
        bit          illegal;
        bit          buserr;
        int          memc;
        bit          pc_src;
        int          regw;
        bit          memwe;
        bit          m2r;
        bit          chk_alu;
        logic [1:0]  aop;
        bit          asrc;
    } vec_t;

    int          nchk = 0;
    int          nerr = 0;
    int          ntxn = 0;
    longint      exp_retired = 0;
    bit          in_fetch = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (txn %0d)", name, act, exp, ntxn);
        end
    endtask

    // Transaction-level expectation derived from the instruction set and bus rules.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   k;
        int   f;
        r = v;
        r.cycles = 0; r.retire = 0; r.illegal = 0; r.buserr = 0; r.memc = 0;
        r.pc_src = 0; r.regw = 0; r.memwe = 0; r.m2r = 0; r.chk_alu = 0;
        r.aop = 2'b00; r.asrc = 0;
        if (v.op == 11'b10001011000 || v.op == 11'b11001011000 ||
            v.op == 11'b10001010000 || v.op == 11'b10101010000) k = 0;
        else if (v.op == 11'b11111000010) k = 1;
        else if (v.op == 11'b11111000000) k = 2;
        else if (v.op[10:3] == 8'b10110100) k = 3;
        else if (v.op[10:5] == 6'b000101) k = 4;
        else k = 5;
        if (v.ifd >= 16) begin
            r.cycles = 16;
            r.buserr = 1;
            return r;
        end
        f = v.ifd + 1;
        case (k)
            0: begin
                r.cycles = f + 3; r.retire = 1; r.regw = 1;
                r.chk_alu = 1; r.aop = 2'b10; r.asrc = 0;
            end
            1, 2: begin
                r.chk_alu = 1; r.aop = 2'b00; r.asrc = 1;
                r.memwe = (k == 2);
                if (v.md >= 16) begin
                    r.memc = 16; r.cycles = f + 2 + 16; r.buserr = 1;
                end else begin
                    r.memc = v.md + 1;
                    r.retire = 1;
                    r.cycles = f + 2 + r.memc + ((k == 1) ? 1 : 0);
                    if (k == 1) begin
                        r.regw = 1; r.m2r = 1;
                    end
                end
            end
            3: begin
                r.cycles = f + 2; r.retire = 1; r.pc_src = v.zero;
                r.chk_alu = 1; r.aop = 2'b01; r.asrc = 0;
            end
            4: begin
                r.cycles = f + 2; r.retire = 1; r.pc_src = 1;
            end
            default: begin
                r.cycles = f + 1; r.illegal = 1;
            end
        endcase
        return r;
    endfunction

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; if_ready = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        in_fetch = 1'b0;
        exp_retired = 0;
    endtask

    task automatic run_vec(input vec_t e);
        int         cyc = 0, fcnt = 0, mcnt = 0, irw = 0, regw = 0, pcw = 0, viol = 0;
        bit         memwe_seen = 0, m2r = 0, psrc = 0, asrc = 0, done = 0, halted = 0;
        logic [1:0] aop = 2'b11;
        ntxn++;
        opcode = e.op; zero = e.zero; if_ready = 1'b0; mem_ready = 1'b0;
        if (!in_fetch) begin
            run = 1'b1;
            @(posedge clk); #1;
        end
        chk("start_if_req", if_req, 1);
        run = e.run_after;
        while (!done && !halted && cyc < 60) begin
            if (!busy) begin
                halted = 1;
            end else begin
                if_ready  = if_req && (fcnt >= e.ifd);
                mem_ready = mem_req && (mcnt >= e.md);
                #1;
                if (if_req) fcnt++;
                if (mem_req) mcnt++;
                if (ir_write) irw++;
                if (mem_req && mem_we) memwe_seen = 1;
                if (reg_write) begin regw++; m2r = mem_to_reg; end
                if (pc_write) begin pcw++; psrc = pc_src; end
                if ((pc_write || reg_write) && mem_req && !mem_ready) viol++;
                if (cyc == e.ifd + 2) begin aop = alu_op; asrc = alu_src; end
                cyc++;
                if (pc_write) done = 1;
                @(posedge clk); #1;
                if_ready = 1'b0; mem_ready = 1'b0;
            end
        end
        chk("cycles", cyc, e.cycles);
        chk("pc_write_count", pcw, e.retire ? 1 : 0);
        chk("ir_write_count", irw, (e.ifd < 16) ? 1 : 0);
        chk("mem_req_cycles", mcnt, e.memc);
        chk("mem_we", memwe_seen, e.memwe);
        chk("reg_write_count", regw, e.regw);
        chk("no_write_while_mem_wait", viol, 0);
        if (e.regw != 0) chk("mem_to_reg", m2r, e.m2r);
        if (e.retire) chk("pc_src", psrc, e.pc_src);
        if (e.chk_alu) begin
            chk("alu_op", aop, e.aop);
            chk("alu_src", asrc, e.asrc);
        end
        chk("illegal", illegal, e.illegal);
        chk("bus_error", bus_error, e.buserr);
        $display("txn %0d op=%b zero=%0d ifd=%0d md=%0d run=%0d cycles=%0d retired=%0d halted=%0d",
                 ntxn, e.op, e.zero, e.ifd, e.md, e.run_after, cyc, instr_retired, halted);
        if (e.retire) begin
            exp_retired++;
            chk("instr_retired", instr_retired, exp_retired);
            chk("busy_after_retire", busy, e.run_after);
            in_fetch = e.run_after;
        end else begin
            chk("halted", halted, 1);
            for (int i = 0; i < 4; i++) begin
                run = ~run;
                @(posedge clk); #1;
                chk("halt_busy", busy, 0);
                chk("halt_if_req", if_req, 0);
                chk("halt_flags", {illegal, bus_error}, {e.illegal, e.buserr});
            end
            do_reset();
            chk("flags_after_reset", {illegal, bus_error}, 0);
            chk("retired_after_reset", instr_retired, 0);
        end
    endtask

    localparam int NTBL = 15;
    vec_t tbl[NTBL];

    function automatic vec_t mk(input logic [10:0] op, input bit z, input int ifd, input int md,
                                input bit ra, input int cyc, input bit ret, input bit ill,
                                input bit be, input int memc, input bit ps, input int rw,
                                input bit mw, input bit m2r, input bit ca, input logic [1:0] ao,
                                input bit as);
        vec_t v;
        v.op = op; v.zero = z; v.ifd = ifd; v.md = md; v.run_after = ra;
        v.cycles = cyc; v.retire = ret; v.illegal = ill; v.buserr = be; v.memc = memc;
        v.pc_src = ps; v.regw = rw; v.memwe = mw; v.m2r = m2r; v.chk_alu = ca;
        v.aop = ao; v.asrc = as;
        return v;
    endfunction

    initial begin
        vec_t v;
        vec_t e;
        int   mseen;
        logic [10:0] op;

        reset = 1'b1; run = 1'b0; opcode = '0; zero = 1'b0; if_ready = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_outputs", {if_req, ir_write, alu_op, alu_src, mem_req, mem_we, mem_to_reg,
                              reg_write, pc_write, pc_src, busy, illegal, bus_error}, 0);
        chk("reset_retired", instr_retired, 0);
        @(posedge clk); #1;
        chk("idle_without_run", busy, 0);

        //            op             z ifd md  ra cyc ret ill be memc ps rw mw m2r ca aop   as
        tbl[0]  = mk(11'b10001011000, 0, 0, 0,   1, 4,  1,  0,  0, 0,   0, 1, 0, 0,  1, 2'b10, 0);
        tbl[1]  = mk(11'b11111000010, 0, 0, 3,   1, 8,  1,  0,  0, 4,   0, 1, 0, 1,  1, 2'b00, 1);
        tbl[2]  = mk(11'b10110100101, 1, 0, 0,   1, 3,  1,  0,  0, 0,   1, 0, 0, 0,  1, 2'b01, 0);
        tbl[3]  = mk(11'b10110100011, 0, 0, 0,   1, 3,  1,  0,  0, 0,   0, 0, 0, 0,  1, 2'b01, 0);
        tbl[4]  = mk(11'b00010111011, 0, 0, 0,   1, 3,  1,  0,  0, 0,   1, 0, 0, 0,  0, 2'b00, 0);
        tbl[5]  = mk(11'b11111000000, 0, 0, 15,  1, 19, 1,  0,  0, 16,  0, 0, 1, 0,  1, 2'b00, 1);
        tbl[6]  = mk(11'b11111000010, 0, 0, 0,   0, 5,  1,  0,  0, 1,   0, 1, 0, 1,  1, 2'b00, 1);
        tbl[7]  = mk(11'b11001011000, 0, 2, 0,   1, 6,  1,  0,  0, 0,   0, 1, 0, 0,  1, 2'b10, 0);
        tbl[8]  = mk(11'b10001010000, 0, 0, 0,   1, 4,  1,  0,  0, 0,   0, 1, 0, 0,  1, 2'b10, 0);
        tbl[9]  = mk(11'b10101010000, 0, 1, 0,   1, 5,  1,  0,  0, 0,   0, 1, 0, 0,  1, 2'b10, 0);
        tbl[10] = mk(11'b11111000000, 0, 0, 0,   1, 4,  1,  0,  0, 1,   0, 0, 1, 0,  1, 2'b00, 1);
        tbl[11] = mk(11'b11111111111, 0, 0, 0,   1, 2,  0,  1,  0, 0,   0, 0, 0, 0,  0, 2'b00, 0);
        tbl[12] = mk(11'b11111000000, 0, 0, 100, 1, 19, 0,  0,  1, 16,  0, 0, 1, 0,  1, 2'b00, 1);
        tbl[13] = mk(11'b10001011000, 0, 100, 0, 1, 16, 0,  0,  1, 0,   0, 0, 0, 0,  0, 2'b00, 0);
        tbl[14] = mk(11'b11111000010, 0, 1, 2,   1, 8,  1,  0,  0, 3,   0, 1, 0, 1,  1, 2'b00, 1);

        for (int i = 0; i < NTBL; i++) run_vec(tbl[i]);

        // Reset asserted while a load waits in the memory phase.
        run_vec(tbl[0]);
        chk("retired_before_abort", instr_retired, exp_retired);
        opcode = 11'b11111000010; run = 1'b1; mseen = 0;
        for (int i = 0; i < 10 && mseen < 2; i++) begin
            if_ready = if_req; mem_ready = 1'b0;
            #1;
            if (mem_req) mseen++;
            if (mseen < 2) begin
                @(posedge clk); #1;
            end
        end
        chk("reached_mem", mseen, 2);
        reset = 1'b1; if_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_outputs", {if_req, ir_write, alu_op, alu_src, mem_req, mem_we, mem_to_reg,
                              reg_write, pc_write, pc_src, busy, illegal, bus_error}, 0);
        chk("abort_retired", instr_retired, 0);
        $display("txn reset during memory phase: busy=%0d retired=%0d", busy, instr_retired);
        in_fetch = 1'b0; exp_retired = 0; run = 1'b0;

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 8))
                0: op = 11'b10001011000;
                1: op = 11'b11001011000;
                2: op = 11'b10001010000;
                3: op = 11'b10101010000;
                4: op = 11'b11111000010;
                5: op = 11'b11111000000;
                6: op = 11'b10110100000 | 11'($urandom_range(0, 7));
                7: op = 11'b00010100000 | 11'($urandom_range(0, 31));
                default: op = 11'($urandom_range(0, 2047));
            endcase
            v.op = op;
            v.zero = 1'($urandom_range(0, 1));
            v.ifd = ($urandom_range(0, 15) == 0) ? 16 : $urandom_range(0, 3);
            v.md = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 17) : $urandom_range(0, 4);
            v.run_after = ($urandom_range(0, 3) != 0);
            e = model(v);
            run_vec(e);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
